// File: rtl/reg_arbiter.sv
// Four-requester round-robin arbiter in front of one shared register.
// A winner is granted for one cycle, writes its WDATA slice into Q if it
// still requests, gets a one-cycle ACK, and the priority pointer then
// rotates to the requester after it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; arbitrate among REQ starting at PTR
// GRANT | GNT high for the latched grantee; write if REQ still held
// ACKN  | ACK high for the grantee; rotate PTR past it
module reg_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [3:0]         REQ,
    input  logic [4*WIDTH-1:0] WDATA,
    output logic [3:0]         GNT,
    output logic [3:0]         ACK,
    output logic [WIDTH-1:0]   Q,
    output logic [1:0]         OWNER,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACKN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [1:0]       grantee;
    logic [1:0]       grantee_nxt;
    logic [1:0]       owner_nxt;
    logic [1:0]       pick;
    logic             found;
    logic [3:0]       gnt_nxt;
    logic [3:0]       ack_nxt;
    logic [WIDTH-1:0] q_nxt;

    // Rotating-priority scan: first asserted REQ at PTR, PTR+1, ... (mod 4).
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (!found && REQ[ptr + 2'(j)]) begin
                pick  = ptr + 2'(j);
                found = 1'b1;
            end
        end
    end

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        grantee_nxt = grantee;
        owner_nxt   = OWNER;
        q_nxt       = Q;
        gnt_nxt     = 4'b0000;
        ack_nxt     = 4'b0000;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt     = 4'b0001 << pick;
                    grantee_nxt = pick;
                    state_nxt   = GRANT;
                end
            end
            GRANT: begin
                // A withdrawn request aborts quietly: no write, PTR not rotated.
                if (REQ[grantee]) begin
                    q_nxt     = WDATA[grantee*WIDTH +: WIDTH];
                    owner_nxt = grantee;
                    ack_nxt   = 4'b0001 << grantee;
                    state_nxt = ACKN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACKN: begin
                ptr_nxt   = grantee + 2'd1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            grantee <= 2'd0;
            OWNER   <= 2'd0;
            Q       <= '0;
            GNT     <= 4'b0000;
            ACK     <= 4'b0000;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            grantee <= grantee_nxt;
            OWNER   <= owner_nxt;
            Q       <= q_nxt;
            GNT     <= gnt_nxt;
            ACK     <= ack_nxt;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed scenarios plus a random run of reg_arbiter, checked every cycle
// against a transaction-level model of the arbitration protocol.
module tb_reg_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] wdata;
    logic [3:0]     gnt;
    logic [3:0]     ack;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = idle, 1 = granted, 2 = acknowledged.
    int           m_phase;
    int           m_ptr;
    int           m_grantee;
    int           m_owner;
    logic [3:0]   m_gnt;
    logic [3:0]   m_ack;
    logic [W-1:0] m_q;

    int        ack_idx[$];
    int        ack_q[$];
    int        ack_cyc[$];
    int        busy_cnt;
    int        exp_idx[5] = '{0, 1, 2, 3, 0};
    int        exp_q[5]   = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

    always #5 clk = ~clk;

    reg_arbiter #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .REQ   (req),
        .WDATA (wdata),
        .GNT   (gnt),
        .ACK   (ack),
        .Q     (q),
        .OWNER (owner),
        .BUSY  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase   = 0;
        m_ptr     = 0;
        m_grantee = 0;
        m_owner   = 0;
        m_gnt     = 4'b0000;
        m_ack     = 4'b0000;
        m_q       = '0;
    endfunction

    function automatic void model_step();
        case (m_phase)
            0: begin
                m_ack = 4'b0000;
                if (req != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        if (req[(m_ptr + k) % 4]) begin
                            m_grantee = (m_ptr + k) % 4;
                            break;
                        end
                    end
                    m_gnt   = 4'b0001 << m_grantee;
                    m_phase = 1;
                end else begin
                    m_gnt = 4'b0000;
                end
            end
            1: begin
                m_gnt = 4'b0000;
                if (req[m_grantee]) begin
                    m_q     = wdata[m_grantee*W +: W];
                    m_owner = m_grantee;
                    m_ack   = 4'b0001 << m_grantee;
                    m_phase = 2;
                end else begin
                    m_ack   = 4'b0000;
                    m_phase = 0;
                end
            end
            default: begin
                m_ack   = 4'b0000;
                m_ptr   = (m_grantee + 1) % 4;
                m_phase = 0;
            end
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".gnt"},   32'(gnt),   32'(m_gnt));
        chk({tag, ".ack"},   32'(ack),   32'(m_ack));
        chk({tag, ".q"},     32'(q),     32'(m_q));
        chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
        chk({tag, ".busy"},  32'(busy),  32'(m_phase != 0));
        chk({tag, ".excl"},  32'($onehot0(gnt) && $onehot0(ack) && ((gnt & ack) == 4'b0000)), 32'd1);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #2;
        check_all(tag);
    endtask

    // Called 2 time units after a rising edge; reset pulse ends before the next edge.
    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        #1 rst_n = 1'b1;
    endtask

    function automatic int onehot_index(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        wdata = '0;
        model_reset();
        #3;
        check_all("reset");
        #4 rst_n = 1'b1;

        // Single request from requester 0.
        req      = 4'b0001;
        wdata    = 32'h0000_00A5;
        busy_cnt = 0;
        cycle("single1");
        busy_cnt += int'(busy);
        chk("single.gnt", 32'(gnt), 32'h1);
        cycle("single2");
        busy_cnt += int'(busy);
        chk("single.q", 32'(q), 32'hA5);
        chk("single.ack", 32'(ack), 32'h1);
        chk("single.owner", 32'(owner), 32'h0);
        req = 4'b0000;
        cycle("single3");
        busy_cnt += int'(busy);
        cycle("single4");
        busy_cnt += int'(busy);
        chk("single.busy_cycles", 32'(busy_cnt), 32'd2);

        // Round robin with all four requesting.
        pulse_reset();
        req   = 4'b1111;
        wdata = 32'h4332_2110;
        for (int c = 1; c <= 15; c++) begin
            cycle("rr");
            if (ack != 4'b0000) begin
                ack_idx.push_back(onehot_index(ack));
                ack_q.push_back(int'(q));
                ack_cyc.push_back(c);
            end
        end
        chk("rr.count", 32'(ack_idx.size()), 32'd5);
        for (int i = 0; i < 5 && i < ack_idx.size(); i++) begin
            chk("rr.order", 32'(ack_idx[i]), 32'(exp_idx[i]));
            chk("rr.q", 32'(ack_q[i]), 32'(exp_q[i]));
            if (i > 0) chk("rr.spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end
        req = 4'b0000;
        cycle("rr_idle");

        // Pointer wrap: requester 2 writes, then 3 and 0 compete.
        pulse_reset();
        req   = 4'b0100;
        wdata = 32'h0077_0000;
        cycle("wrap1");
        cycle("wrap2");
        req   = 4'b1001;
        wdata = 32'h9900_0088;
        cycle("wrap3");
        cycle("wrap4");
        chk("wrap.first_gnt", 32'(gnt), 32'h8);
        cycle("wrap5");
        chk("wrap.q3", 32'(q), 32'h99);
        cycle("wrap6");
        cycle("wrap7");
        chk("wrap.second_gnt", 32'(gnt), 32'h1);
        cycle("wrap8");
        chk("wrap.q0", 32'(q), 32'h88);
        req = 4'b0000;
        cycle("wrap9");

        // Withdrawal during GRANT.
        pulse_reset();
        req   = 4'b1000;
        wdata = 32'h3C00_0000;
        cycle("wd1");
        cycle("wd2");
        req = 4'b0000;
        cycle("wd3");
        req   = 4'b0100;
        wdata = 32'h00BB_AA00;
        cycle("wd4");
        chk("wd.gnt2", 32'(gnt), 32'h4);
        req = 4'b0000;
        cycle("wd5");
        chk("wd.no_ack", 32'(ack), 32'h0);
        chk("wd.q_kept", 32'(q), 32'h3C);
        chk("wd.owner_kept", 32'(owner), 32'h3);
        chk("wd.idle", 32'(busy), 32'h0);
        req = 4'b0110;
        cycle("wd6");
        chk("wd.next_gnt", 32'(gnt), 32'h2);
        cycle("wd7");
        chk("wd.next_q", 32'(q), 32'hAA);
        req = 4'b0000;
        cycle("wd8");

        // Asynchronous reset in the middle of GRANT.
        req   = 4'b0001;
        wdata = 32'h0000_005A;
        cycle("ar1");
        chk("ar.granted", 32'(gnt), 32'h1);
        pulse_reset();
        chk("ar.gnt", 32'(gnt), 32'h0);
        chk("ar.q", 32'(q), 32'h0);
        chk("ar.busy", 32'(busy), 32'h0);
        req = 4'b0000;
        cycle("ar2");
        chk("ar.no_ack", 32'(ack), 32'h0);
        cycle("ar3");

        // Non-grantee slices toggle while requester 1 writes.
        pulse_reset();
        req   = 4'b0010;
        wdata = 32'h0000_5C00;
        for (int i = 0; i < 2; i++) begin
            wdata[7:0]   = 8'($urandom);
            wdata[31:24] = ~wdata[7:0];
            cycle("iso");
        end
        chk("iso.q", 32'(q), 32'h5C);
        chk("iso.owner", 32'(owner), 32'h1);
        req = 4'b0000;
        cycle("iso_idle");

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            wdata = $urandom;
            cycle("rand");
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
